spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI mode-0 slave; the far end of the SPI master on the same bus (SCLK idle low, data sampled on SCLK rise, driven on SCLK fall, SS_N active low).
- Oversamples SCLK/SS_N/MOSI in the local clk domain through synchronizers and shifts MOSI into a receive register.
- Shifts a host-supplied word out on MISO.
- Presents each completed frame to the host with a one-cycle valid pulse and the received bit count.

Parameters:
- SPI_MAXLEN, 32, width of tx/rx shift registers and maximum frame length.
- SYNC_STAGES, 2, flops in each input synchronizer (>=2).

Ports:
- clk  input  1  system clock.
- sresetn  input  1  reset, synchronous to clk, active low.
- SCLK  input  1  SPI clock from master (asynchronous).
- SS_N  input  1  slave select from master, low during a frame (asynchronous).
- MOSI  input  1  data from master (asynchronous).
- MISO  output  1  data to master.
- tx_data  input  SPI_MAXLEN  word to transmit; captured at frame start.
- rx_data  output  SPI_MAXLEN  received bits; last bit in [0].
- rx_nbits  output  $clog2(SPI_MAXLEN)+1  count of SCLK rising edges in last frame, saturating at SPI_MAXLEN.
- rx_valid  output  1  one-cycle pulse: rx_data/rx_nbits updated.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Sync and edge detect:
  - SCLK, SS_N and MOSI each pass through SYNC_STAGES flops.
  - A further flop on SCLK/SS_N yields sclk_rise, sclk_fall, ss_fall and ss_rise.
  - Sync reset values: SS_N chain 1, SCLK chain 0, MOSI chain 0.
- Timing constraint: master CLK_DIVIDE >= 4*(SYNC_STAGES+2), i.e. >= 16 at default. Below that, behaviour is undefined.
- Reset (sresetn=0 at a clk edge):
  - Outputs: MISO=0, rx_data=0, rx_nbits=0, rx_valid=0, busy=0.
  - Internal: state IDLE, shift registers 0.
- States: IDLE, ACTIVE.
- IDLE:
  - SCLK edges are ignored.
  - On ss_fall: tx_shift<=tx_data, rx_shift<=0, cnt<=0, busy<=1, go to ACTIVE.
- ACTIVE:
  - sclk_rise: rx_shift<={rx_shift[SPI_MAXLEN-2:0], mosi_s}; cnt<=cnt+1, saturating at SPI_MAXLEN.
  - sclk_fall: tx_shift<={tx_shift[SPI_MAXLEN-2:0],1'b0}.
  - ss_rise: rx_data<=rx_shift, rx_nbits<=cnt, rx_valid<=1 for exactly one cycle, busy<=0, go to IDLE.
  - Simultaneous sclk_rise and ss_rise: the bit is shifted in and counted before the frame is latched.
- MISO:
  - Registered.
  - Equals tx_shift[SPI_MAXLEN-1] while in ACTIVE; 0 in IDLE.
  - First bit is tx_data[SPI_MAXLEN-1], valid within 2 clk of ss_fall detection.
  - An n-bit frame returns tx_data[SPI_MAXLEN-1 -: n] to the master.
- Frames longer than SPI_MAXLEN: rx_data holds the last SPI_MAXLEN bits; rx_nbits=SPI_MAXLEN. MISO shifts out zeros after the word is exhausted.
- Zero-bit frame (SS_N low then high, no SCLK): rx_valid pulses, rx_nbits=0, rx_data=0.
- rx_data/rx_nbits hold stable until the next rx_valid. tx_data is sampled only at ss_fall.
- Reset mid-frame: no rx_valid is issued. If SS_N is still low after reset, the frame is ignored until SS_N goes high and falls again.

Optional Feature:
- Macro: SPI_SLV_OVERRUN_EN.
- Defined:
  - Adds output rx_overrun (1 bit, reset 0).
  - Set with rx_valid when the frame had more than SPI_MAXLEN SCLK rising edges; cleared with the next rx_valid of a legal frame.
  - Requires an internal extra-edge flag.
- Not defined: no port and no flag; over-length frames behave as above, silently.

Test Plan:
- Reset, SS_N=1, no activity -> all outputs 0, rx_valid never asserts.
- Master CLK_DIVIDE=16, 8-bit frame, MOSI=0xA5, tx_data=0xC3000000 -> master receives 0xC3; rx_data=0x000000A5, rx_nbits=8, one rx_valid pulse, busy high throughout the frame.
- 32-bit frame, MOSI=0xDEADBEEF, tx_data=0x12345678 -> rx_data=0xDEADBEEF, rx_nbits=32, master receives 0x12345678.
- 36-bit frame, MOSI=0xF_0000_0001 -> rx_data=0x00000001, rx_nbits=32; with SPI_SLV_OVERRUN_EN, rx_overrun=1.
- SS_N pulsed low 40 clk with no SCLK -> rx_valid pulse, rx_nbits=0, rx_data=0.
- sresetn asserted after 5 bits of a frame, SS_N held low to frame end -> no rx_valid. A subsequent normal 8-bit frame 0x3C -> rx_data=0x3C, rx_nbits=8.

Source files
------------

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0 slave. SCLK, SS_N and MOSI are oversampled in
//               the clk domain. MOSI is shifted into a receive register, and
//               a host word is shifted out on MISO. Each completed frame is
//               reported with a one-cycle rx_valid pulse and a bit count.
// Options     : define SPI_SLV_OVERRUN_EN to add the rx_overrun output,
//               which flags frames longer than SPI_MAXLEN bits.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int SPI_MAXLEN  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_nbits,
    output logic                          rx_valid,
    output logic                          busy
`ifdef SPI_SLV_OVERRUN_EN
    ,
    output logic                          rx_overrun
`endif
);

    localparam int            CW       = $clog2(SPI_MAXLEN) + 1;
    localparam logic [CW-1:0] C_MAXCNT = CW'(SPI_MAXLEN);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_d;
    logic                    r_ss_d;
    logic [SYNC_STAGES:0]    r_warm;

    logic                    w_sclk_s;
    logic                    w_ss_s;
    logic                    w_mosi_s;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_ss_fall;
    logic                    w_ss_rise;
    logic                    w_warm;

    logic [SPI_MAXLEN-1:0]   r_tx_shift;
    logic [SPI_MAXLEN-1:0]   r_rx_shift;
    logic [CW-1:0]           r_cnt;
    logic [SPI_MAXLEN-1:0]   w_tx_next;
    logic [SPI_MAXLEN-1:0]   w_rx_next;
    logic [CW-1:0]           w_cnt_next;
    logic                    w_frame_done;
`ifdef SPI_SLV_OVERRUN_EN
    logic                    r_extra;
    logic                    w_extra_next;
`endif

    // Input synchronizers, edge-detect delay flops and post-reset warm-up tracker.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_warm      <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_N};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
            r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_ss_fall   = ~w_ss_s   &  r_ss_d;
    assign w_ss_rise   =  w_ss_s   & ~r_ss_d;
    // The SS_N edge detector only sees real pin samples once the whole chain
    // has refilled after reset; a select already low during reset would
    // otherwise look like a fresh falling edge and start a bogus frame.
    assign w_warm      = r_warm[SYNC_STAGES];

    // Next-state and shift-register update logic.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx_shift;
        w_rx_next    = r_rx_shift;
        w_cnt_next   = r_cnt;
        w_frame_done = 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
        w_extra_next = r_extra;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall && w_warm) begin
                    w_state_next = ST_ACTIVE;
                    w_tx_next    = tx_data;
                    w_rx_next    = '0;
                    w_cnt_next   = '0;
`ifdef SPI_SLV_OVERRUN_EN
                    w_extra_next = 1'b0;
`endif
                end
            end
            ST_ACTIVE: begin
                if (w_sclk_rise) begin
                    w_rx_next = {r_rx_shift[SPI_MAXLEN-2:0], w_mosi_s};
                    if (r_cnt != C_MAXCNT) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
`ifdef SPI_SLV_OVERRUN_EN
                if (w_sclk_rise && (r_cnt == C_MAXCNT)) begin
                    w_extra_next = 1'b1;
                end
`endif
                if (w_sclk_fall) begin
                    w_tx_next = {r_tx_shift[SPI_MAXLEN-2:0], 1'b0};
                end
                // The latch uses the post-shift values so a final SCLK rise
                // coinciding with SS_N rise is still counted.
                if (w_ss_rise) begin
                    w_state_next = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state    <= ST_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_cnt      <= '0;
            MISO       <= 1'b0;
            rx_data    <= '0;
            rx_nbits   <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
            r_extra    <= 1'b0;
            rx_overrun <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_tx_shift <= w_tx_next;
            r_rx_shift <= w_rx_next;
            r_cnt      <= w_cnt_next;
            busy       <= (w_state_next == ST_ACTIVE);
            MISO       <= (w_state_next == ST_ACTIVE) ? w_tx_next[SPI_MAXLEN-1] : 1'b0;
            rx_valid   <= w_frame_done;
`ifdef SPI_SLV_OVERRUN_EN
            r_extra    <= w_extra_next;
`endif
            if (w_frame_done) begin
                rx_data  <= w_rx_next;
                rx_nbits <= w_cnt_next;
`ifdef SPI_SLV_OVERRUN_EN
                rx_overrun <= w_extra_next;
`endif
            end
        end
    end

endmodule
`default_nettype wire
